// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: serial operand load, 16-opcode execute, result on uo_out, C/Z on uio_out[7:6].
// Define ALU_MUL_EN to build the 8x8 multiplier for MULL/MULH; otherwise those opcodes return zero.
module alu_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_LOADA = 2'b01,
    CMD_LOADB = 2'b10,
    CMD_EXEC  = 2'b11
  } cmd_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_ADC  = 4'd2,  OP_SBC  = 4'd3,
    OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR  = 4'd6,  OP_NOT  = 4'd7,
    OP_SHL  = 4'd8,  OP_SHR  = 4'd9,  OP_ASR  = 4'd10, OP_ROL  = 4'd11,
    OP_ROR  = 4'd12, OP_MULL = 4'd13, OP_MULH = 4'd14, OP_CMP  = 4'd15
  } op_t;

  logic [7:0] a_q, b_q, r_q;
  logic       c_q, z_q;

  cmd_t       cmd;
  op_t        op;
  logic [7:0] r_d;
  logic       c_d, z_d;
  logic [8:0] arith;
  logic [1:0] unused_uio;

  assign cmd        = cmd_t'(uio_in[5:4]);
  assign op         = op_t'(uio_in[3:0]);
  assign unused_uio = uio_in[7:6];

`ifdef ALU_MUL_EN
  logic [15:0] prod;
  assign prod = {8'd0, a_q} * {8'd0, b_q};
`endif

  always_comb begin
    r_d   = r_q;
    c_d   = 1'b0;
    arith = 9'd0;
    case (op)
      OP_ADD: begin
        arith = {1'b0, a_q} + {1'b0, b_q};
        r_d   = arith[7:0];
        c_d   = arith[8];
      end
      OP_ADC: begin
        arith = {1'b0, a_q} + {1'b0, b_q} + {8'd0, c_q};
        r_d   = arith[7:0];
        c_d   = arith[8];
      end
      // 9-bit subtraction: bit 8 is the borrow, i.e. A < B (+C)
      OP_SUB: begin
        arith = {1'b0, a_q} - {1'b0, b_q};
        r_d   = arith[7:0];
        c_d   = arith[8];
      end
      OP_SBC: begin
        arith = {1'b0, a_q} - {1'b0, b_q} - {8'd0, c_q};
        r_d   = arith[7:0];
        c_d   = arith[8];
      end
      OP_AND: r_d = a_q & b_q;
      OP_OR:  r_d = a_q | b_q;
      OP_XOR: r_d = a_q ^ b_q;
      OP_NOT: r_d = ~a_q;
      OP_SHL: begin r_d = {a_q[6:0], 1'b0};     c_d = a_q[7]; end
      OP_SHR: begin r_d = {1'b0, a_q[7:1]};     c_d = a_q[0]; end
      OP_ASR: begin r_d = {a_q[7], a_q[7:1]};   c_d = a_q[0]; end
      OP_ROL: begin r_d = {a_q[6:0], a_q[7]};   c_d = a_q[7]; end
      OP_ROR: begin r_d = {a_q[0], a_q[7:1]};   c_d = a_q[0]; end
`ifdef ALU_MUL_EN
      OP_MULL: begin r_d = prod[7:0]; c_d = |prod[15:8]; end
      OP_MULH: r_d = prod[15:8];
`else
      OP_MULL: r_d = 8'd0;
      OP_MULH: r_d = 8'd0;
`endif
      OP_CMP: c_d = (a_q < b_q);
      default: r_d = r_q;
    endcase
    // CMP leaves R alone and reports equality on Z instead
    z_d = (op == OP_CMP) ? (a_q == b_q) : (r_d == 8'd0);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_q <= 8'd0;
      b_q <= 8'd0;
      r_q <= 8'd0;
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else if (ena) begin
      case (cmd)
        CMD_LOADA: a_q <= ui_in;
        CMD_LOADB: b_q <= ui_in;
        CMD_EXEC: begin
          r_q <= r_d;
          c_q <= c_d;
          z_q <= z_d;
        end
        default: ;
      endcase
    end
  end

  assign uo_out  = r_q;
  assign uio_out = {c_q, z_q, 6'd0};
  assign uio_oe  = 8'hC0;

endmodule

// File: tb/tb_alu_8bit.sv
// Directed bench for alu_8bit: hand-computed vectors for reset, arithmetic, logic, shifts, multiply and enable gating.
// Multiply expectations follow ALU_MUL_EN exactly as the design build does.
module tb_alu_8bit;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_errors = 0;

  alu_8bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flags(input logic c, input logic z);
    return {c, z, 6'd0};
  endfunction

  // one command on one rising edge, sampled 1 time unit after the edge
  task automatic issue(input logic [1:0] cmd, input logic [3:0] op, input logic [7:0] data, input logic en);
    @(negedge clk);
    ena    = en;
    ui_in  = data;
    uio_in = {2'b00, cmd, op};
    @(posedge clk);
    #1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    issue(2'b01, 4'd0, a, 1'b1);
    issue(2'b10, 4'd0, b, 1'b1);
  endtask

  task automatic exec_chk(input string tag, input logic [3:0] op, input logic [7:0] exp_r,
                          input logic exp_c, input logic exp_z);
    issue(2'b11, op, 8'hA5, 1'b1);
    check({tag, ".r"}, uo_out, exp_r);
    check({tag, ".f"}, uio_out, flags(exp_c, exp_z));
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst.uo", uo_out, 8'h00);
    check("rst.uio", uio_out, 8'h00);
    check("rst.oe", uio_oe, 8'hC0);
    @(negedge clk);
    rst_n = 1'b0;

    // activity, then asynchronous reset between edges
    load_ab(8'h37, 8'h11);
    exec_chk("pre_add", 4'd0, 8'h48, 1'b0, 1'b0);
    exec_chk("pre_shl", 4'd8, 8'h6E, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("arst.uo", uo_out, 8'h00);
    check("arst.uio", uio_out, 8'h00);
    check("arst.oe", uio_oe, 8'hC0);
    @(negedge clk);
    rst_n = 1'b0;
    exec_chk("rst_add", 4'd0, 8'h00, 1'b0, 1'b1);

    // add with overflow, then ADC consuming that carry
    load_ab(8'hF0, 8'h20);
    exec_chk("add_ovf", 4'd0, 8'h10, 1'b1, 1'b0);
    load_ab(8'h01, 8'h01);
    exec_chk("adc", 4'd2, 8'h03, 1'b0, 1'b0);

    // subtract with borrow, then compare equal
    load_ab(8'h10, 8'h20);
    exec_chk("sub", 4'd1, 8'hF0, 1'b1, 1'b0);
    load_ab(8'h55, 8'h55);
    exec_chk("cmp_eq", 4'd15, 8'hF0, 1'b0, 1'b1);
    load_ab(8'h00, 8'h01);
    exec_chk("cmp_lt", 4'd15, 8'hF0, 1'b1, 1'b0);
    exec_chk("sub_wrap", 4'd1, 8'hFF, 1'b1, 1'b0);
    load_ab(8'h01, 8'h01);
    exec_chk("sub_zero", 4'd1, 8'h00, 1'b0, 1'b1);

    // logic and shifts on A=0x81, B=0x0F
    load_ab(8'h81, 8'h0F);
    exec_chk("and", 4'd4, 8'h01, 1'b0, 1'b0);
    exec_chk("or",  4'd5, 8'h8F, 1'b0, 1'b0);
    exec_chk("xor", 4'd6, 8'h8E, 1'b0, 1'b0);
    exec_chk("not", 4'd7, 8'h7E, 1'b0, 1'b0);
    exec_chk("shl", 4'd8, 8'h02, 1'b1, 1'b0);
    exec_chk("shr", 4'd9, 8'h40, 1'b1, 1'b0);
    exec_chk("asr", 4'd10, 8'hC0, 1'b1, 1'b0);
    exec_chk("rol", 4'd11, 8'h03, 1'b1, 1'b0);
    exec_chk("ror", 4'd12, 8'hC0, 1'b1, 1'b0);
    // back-to-back: SBC uses the C=1 left by ROR: 0x81-0x0F-1
    exec_chk("sbc", 4'd3, 8'h71, 1'b0, 1'b0);
    load_ab(8'hFF, 8'hFF);
    exec_chk("add_ff", 4'd0, 8'hFE, 1'b1, 1'b0);
    load_ab(8'h00, 8'hFF);
    exec_chk("sbc_brw", 4'd3, 8'h00, 1'b1, 1'b1);

    // multiply: 0x12 * 0x34 = 0x03A8
    load_ab(8'h12, 8'h34);
`ifdef ALU_MUL_EN
    exec_chk("mull", 4'd13, 8'hA8, 1'b1, 1'b0);
    exec_chk("mulh", 4'd14, 8'h03, 1'b0, 1'b0);
`else
    exec_chk("mull", 4'd13, 8'h00, 1'b0, 1'b1);
    exec_chk("mulh", 4'd14, 8'h00, 1'b0, 1'b1);
`endif

    // enable gating: execute and load are both ignored with ena=0
    issue(2'b11, 4'd7, 8'h00, 1'b0);
`ifdef ALU_MUL_EN
    check("ena0_exec.r", uo_out, 8'h03);
    check("ena0_exec.f", uio_out, flags(1'b0, 1'b0));
`else
    check("ena0_exec.r", uo_out, 8'h00);
    check("ena0_exec.f", uio_out, flags(1'b0, 1'b1));
`endif
    issue(2'b01, 4'd0, 8'hFF, 1'b0);
    exec_chk("ena0_load", 4'd0, 8'h46, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_8bit.md
# alu_8bit

Registered 8-bit ALU for a Tiny Tapeout user slot. Operands A and B are loaded serially through the dedicated input bus. An execute command then computes one of 16 operations selected by a 4-bit opcode. The result is driven on the dedicated outputs, and carry and zero flags are driven on the bidirectional pins.

## Interface
- No parameters.
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-high: rst_n=1 immediately clears all state. The name follows the slot convention; the polarity is fixed as stated here.
- ena  input  1  slot enable; when 0, all registers hold.
- ui_in  input  8  data bus; operand value for load commands.
- uio_in  input  8  [3:0] opcode, [5:4] command, [7:6] ignored.
- uo_out  output  8  result register R.
- uio_out  output  8  [7] carry flag C, [6] zero flag Z, [5:0] driven 0.
- uio_oe  output  8  constant 8'hC0.

## Operation
- State: A[7:0], B[7:0], R[7:0], C, Z.
- Commands (uio_in[5:4]), sampled on a rising edge while ena=1 and rst_n=0:
  - 00 idle: hold.
  - 01: A <= ui_in.
  - 10: B <= ui_in.
  - 11 execute: R, C and Z <= f(opcode, A, B, C).
- Execute uses register values A, B and C from before the edge.
- Unless noted, Z = (new R == 0).
- Opcodes:
  - 0 ADD: R=A+B; C=bit 8 of the sum.
  - 1 SUB: R=A-B mod 256; C=1 iff A<B (borrow).
  - 2 ADC: R=A+B+C; C=carry out.
  - 3 SBC: R=A-B-C mod 256; C=1 iff A<B+C.
  - 4 AND, 5 OR, 6 XOR: R=A op B; C=0.
  - 7 NOT: R=~A; C=0.
  - 8 SHL: R={A[6:0],0}; C=A[7].
  - 9 SHR: R={0,A[7:1]}; C=A[0].
  - 10 ASR: R={A[7],A[7:1]}; C=A[0].
  - 11 ROL: R={A[6:0],A[7]}; C=A[7].
  - 12 ROR: R={A[0],A[7:1]}; C=A[0].
  - 13 MULL: R=(A*B)[7:0]; C=|(A*B)[15:8].
  - 14 MULH: R=(A*B)[15:8]; C=0.
  - 15 CMP: R unchanged; C=1 iff A<B; Z=(A==B).
- ui_in is ignored during idle and execute.
- uio_oe is fixed, so uio[5:0] are always inputs.

## Timing
- Reset values: A=0, B=0, R=0, C=0, Z=0. Hence uo_out=0x00, uio_out=0x00, uio_oe=0xC0.
- Reset asserted mid-operation clears all state immediately, regardless of clk or ena.
- Load latency: the operand register is updated at the sampling edge and is usable by an execute command on the next cycle.
- Execute latency: 1 cycle. uo_out and the flags are valid right after the edge that sampled command 11 and hold until the next execute or reset.
- Back-to-back executes are allowed; each uses the C produced by the previous one (chaining for ADC/SBC).
- Wrap-around: all arithmetic is modulo 256; no saturation.
- ena=0 on an edge: the command is ignored and all outputs hold.

## Configuration
- ALU_MUL_EN defined: opcodes 13 and 14 implement the 8x8 multiply described above.
- ALU_MUL_EN undefined: no multiplier is synthesized. Opcodes 13 and 14 yield R=0, C=0, Z=1.
- All other opcodes behave identically in both builds.

## Test plan
- Reset: assert rst_n=1 after arbitrary activity -> uo_out=0x00, uio_out=0x00, uio_oe=0xC0; release and execute opcode 0 -> R=0x00, Z=1.
- Add with overflow: A=0xF0, B=0x20, ADD -> R=0x10, C=1, Z=0. Then ADC with A=0x01, B=0x01 -> R=0x03, C=0.
- Subtract and compare: A=0x10, B=0x20, SUB -> R=0xF0, C=1. Then CMP with A=B=0x55 -> R stays 0xF0, C=0, Z=1.
- Logic and shifts: A=0x81, B=0x0F.
  - AND -> 0x01; XOR -> 0x8E.
  - SHL -> 0x02, C=1; ASR -> 0xC0, C=1; ROR -> 0xC0, C=1.
- Multiply (ALU_MUL_EN defined): A=0x12, B=0x34.
  - MULL -> R=0xA8, C=1.
  - MULH -> R=0x03.
  - Without the macro: R=0x00, Z=1.
- Enable gating: ena=0 with command 11 and a new opcode -> outputs unchanged. Load with ena=0 -> A unchanged, verified by a subsequent ADD.
